// File: rtl/data_movement_pkg.sv
// Shared constants for the data_movement datapath slice.
// Holds the datapath width, the zero-register index and the ALU operation codes.
package data_movement_pkg;

    localparam int unsigned XLEN     = 64;
    localparam logic [4:0]  ZERO_REG = 5'd31;

    // Codes 001 and 111 are left unnamed; the ALU drives a zero result for them.
    typedef enum logic [2:0] {
        ALU_PASS_B = 3'b000,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_XOR    = 3'b110
    } alu_op_e;

endpackage

// File: rtl/data_movement_alu.sv
// Combinational 64-bit ALU with negative/zero/overflow/carry flags.
// Carry and overflow are reported only for add and subtract.
module alu
    import data_movement_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_op,
    output logic [XLEN-1:0] o_result,
    output logic            o_negative,
    output logic            o_zero,
    output logic            o_overflow,
    output logic            o_carry_out
);

    logic [XLEN:0]   w_sum;
    logic [XLEN-1:0] w_result;
    logic            w_carry;
    logic            w_overflow;

    always_comb begin
        w_sum      = '0;
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (i_op)
            ALU_PASS_B: w_result = i_b;
            ALU_ADD: begin
                w_sum      = {1'b0, i_a} + {1'b0, i_b};
                w_result   = w_sum[XLEN-1:0];
                w_carry    = w_sum[XLEN];
                w_overflow = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
            end
            ALU_SUB: begin
                // Subtract as A + ~B + 1 so carry_out means "no borrow".
                w_sum      = {1'b0, i_a} + {1'b0, ~i_b} + {{XLEN{1'b0}}, 1'b1};
                w_result   = w_sum[XLEN-1:0];
                w_carry    = w_sum[XLEN];
                w_overflow = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
            end
            ALU_AND: w_result = i_a & i_b;
            ALU_OR:  w_result = i_a | i_b;
            ALU_XOR: w_result = i_a ^ i_b;
            default: w_result = '0;
        endcase
    end

    assign o_result    = w_result;
    assign o_negative  = w_result[XLEN-1];
    assign o_zero      = (w_result == '0);
    assign o_overflow  = w_overflow;
    assign o_carry_out = w_carry;

endmodule

// File: rtl/data_movement_datamem.sv
// Doubleword data memory: synchronous write and clear, combinational gated read.
module datamem
    import data_movement_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 128,
    localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   i_index,
    input  logic [XLEN-1:0] i_wdata,
    input  logic            i_we,
    input  logic            i_re,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_WORDS; i++) begin
                r_mem[i[AW-1:0]] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_index] <= i_wdata;
        end
    end

    assign o_rdata = i_re ? r_mem[i_index] : '0;

endmodule

// File: rtl/data_movement_mux2x5.sv
// 2:1 select of a 5-bit register address.
module mux2x5 (
    input  logic       i_sel,
    input  logic [4:0] i_d0,
    input  logic [4:0] i_d1,
    output logic [4:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/data_movement.sv
// Single-cycle execute/memory/write-back slice: register file, ALU, data memory
// and write-back select. All outputs are combinational from inputs and state.
module data_movement
    import data_movement_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             regWrite,
    input  logic             reg2Loc,
    input  logic             ALUSrc,
    input  logic             dOrImm,
    input  logic [2:0]       ALUOp,
    input  logic             memWrite,
    input  logic             read_enable,
    input  logic             memToReg,
    input  logic             valueToStore,
    input  logic [4:0]       readAddr1,
    input  logic [4:0]       readAddr2,
    input  logic [4:0]       writeAddr,
    input  logic [8:0]       dAddr9,
    input  logic [11:0]      imm12,
    input  logic [XLEN-1:0]  basicAddress,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic [XLEN-1:0]  WriteData
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [XLEN-1:0] r_regs [32];
    logic [4:0]      w_rd2_addr;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_mem_rdata;

    // reg2Loc=0 routes writeAddr to port 2 so STUR can read its source register.
    mux2x5 u_reg2_sel (
        .i_sel (reg2Loc),
        .i_d0  (writeAddr),
        .i_d1  (readAddr2),
        .o_y   (w_rd2_addr)
    );

    assign w_rd1 = (readAddr1  == ZERO_REG) ? '0 : r_regs[readAddr1];
    assign w_rd2 = (w_rd2_addr == ZERO_REG) ? '0 : r_regs[w_rd2_addr];

    assign w_imm   = dOrImm ? {{(XLEN-12){imm12[11]}}, imm12}
                            : {{(XLEN-9){dAddr9[8]}}, dAddr9};
    assign w_alu_b = ALUSrc ? w_imm : w_rd2;

    alu u_alu (
        .i_a         (w_rd1),
        .i_b         (w_alu_b),
        .i_op        (ALUOp),
        .o_result    (w_result),
        .o_negative  (negative),
        .o_zero      (zero),
        .o_overflow  (overflow),
        .o_carry_out (carry_out)
    );

    datamem #(.MEM_WORDS(MEM_WORDS)) u_datamem (
        .clk     (clk),
        .reset   (reset),
        .i_index (w_result[3 +: AW]),
        .i_wdata (w_rd2),
        .i_we    (memWrite),
        .i_re    (read_enable),
        .o_rdata (w_mem_rdata)
    );

    assign WriteData = valueToStore ? basicAddress
                                    : (memToReg ? w_mem_rdata : w_result);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i[4:0]] <= '0;
            end
        end else if (regWrite && (writeAddr != ZERO_REG)) begin
            r_regs[writeAddr] <= WriteData;
        end
    end

endmodule

// File: tb/tb_data_movement.sv
// Self-checking bench for data_movement: directed scenarios plus randomized
// cycles compared against an arithmetic reference model of regs and memory.
module tb_data_movement;

    localparam int unsigned MEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        reset, regWrite, reg2Loc, ALUSrc, dOrImm, memWrite;
    logic        read_enable, memToReg, valueToStore;
    logic [2:0]  ALUOp;
    logic [4:0]  readAddr1, readAddr2, writeAddr;
    logic [8:0]  dAddr9;
    logic [11:0] imm12;
    logic [63:0] basicAddress;
    logic        negative, zero, overflow, carry_out;
    logic [63:0] WriteData;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] m_regs [32];
    logic [63:0] m_mem  [MEM_WORDS];

    logic [63:0] e_wd, e_res, e_rd2;
    logic        e_neg, e_zero, e_ovf, e_cy;
    int unsigned e_idx;

    always #5 clk = ~clk;

    data_movement #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .regWrite     (regWrite),
        .reg2Loc      (reg2Loc),
        .ALUSrc       (ALUSrc),
        .dOrImm       (dOrImm),
        .ALUOp        (ALUOp),
        .memWrite     (memWrite),
        .read_enable  (read_enable),
        .memToReg     (memToReg),
        .valueToStore (valueToStore),
        .readAddr1    (readAddr1),
        .readAddr2    (readAddr2),
        .writeAddr    (writeAddr),
        .dAddr9       (dAddr9),
        .imm12        (imm12),
        .basicAddress (basicAddress),
        .negative     (negative),
        .zero         (zero),
        .overflow     (overflow),
        .carry_out    (carry_out),
        .WriteData    (WriteData)
    );

    // Reference model: evaluate the current inputs against the model state.
    task automatic model_eval();
        logic [63:0]        a, b, imm, rdata, q;
        logic signed [64:0] sw;
        logic [4:0]         a2;
        a     = (readAddr1 == 5'd31) ? 64'd0 : m_regs[readAddr1];
        a2    = reg2Loc ? readAddr2 : writeAddr;
        e_rd2 = (a2 == 5'd31) ? 64'd0 : m_regs[a2];
        imm   = dOrImm ? 64'($signed(imm12)) : 64'($signed(dAddr9));
        b     = ALUSrc ? imm : e_rd2;
        e_cy  = 1'b0;
        e_ovf = 1'b0;
        case (ALUOp)
            3'b000: e_res = b;
            3'b010: begin
                e_res = a + b;
                e_cy  = (e_res < a);
                sw    = $signed({a[63], a}) + $signed({b[63], b});
                e_ovf = (sw[64] != sw[63]);
            end
            3'b011: begin
                e_res = a - b;
                e_cy  = (a >= b);
                sw    = $signed({a[63], a}) - $signed({b[63], b});
                e_ovf = (sw[64] != sw[63]);
            end
            3'b100: e_res = a & b;
            3'b101: e_res = a | b;
            3'b110: e_res = a ^ b;
            default: e_res = 64'd0;
        endcase
        e_neg  = e_res[63];
        e_zero = (e_res == 64'd0);
        q      = (e_res / 64'd8) % 64'(MEM_WORDS);
        e_idx  = q[31:0];
        rdata  = read_enable ? m_mem[e_idx] : 64'd0;
        e_wd   = valueToStore ? basicAddress : (memToReg ? rdata : e_res);
    endtask

    task automatic model_commit();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
            for (int i = 0; i < int'(MEM_WORDS); i++) m_mem[i] = 64'd0;
        end else begin
            if (regWrite && writeAddr != 5'd31) m_regs[writeAddr] = e_wd;
            if (memWrite) m_mem[e_idx] = e_rd2;
        end
    endtask

    // Advance one clock: model sees pre-edge inputs, then inputs may change.
    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; regWrite = 0; reg2Loc = 0; ALUSrc = 0; dOrImm = 0;
        memWrite = 0; read_enable = 0; memToReg = 0; valueToStore = 0;
        ALUOp = 3'b000; readAddr1 = 5'd31; readAddr2 = 5'd0; writeAddr = 5'd0;
        dAddr9 = '0; imm12 = '0; basicAddress = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick();
        clear_inputs();
        #4;
        n_tests++;
        if (WriteData !== 64'd0) begin
            n_fail++; $display("FAIL reset_wd got=%h exp=%h", WriteData, 64'd0);
        end
        n_tests++;
        if ({negative, zero, overflow, carry_out} !== 4'b0100) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=%b", {negative, zero, overflow, carry_out}, 4'b0100);
        end
        tick();
    endtask

    task automatic test_addi();
        clear_inputs();
        ALUSrc = 1; dOrImm = 1; imm12 = 12'h005; ALUOp = 3'b010; regWrite = 1; writeAddr = 5'd1;
        #4;
        n_tests++;
        if (WriteData !== 64'd5) begin
            n_fail++; $display("FAIL addi_wd got=%h exp=%h", WriteData, 64'd5);
        end
        tick();
        clear_inputs();
        readAddr1 = 5'd1; ALUSrc = 1; dOrImm = 1; ALUOp = 3'b010;
        #4;
        n_tests++;
        if (WriteData !== 64'd5) begin
            n_fail++; $display("FAIL addi_readback got=%h exp=%h", WriteData, 64'd5);
        end
        tick();
    endtask

    task automatic test_sub();
        clear_inputs();
        readAddr1 = 5'd1; readAddr2 = 5'd1; reg2Loc = 1; ALUOp = 3'b011;
        #4;
        n_tests++;
        if ({WriteData, negative, zero, overflow, carry_out} !== {64'd0, 4'b0101}) begin
            n_fail++; $display("FAIL sub_zero got=%h/%b exp=%h/%b", WriteData,
                {negative, zero, overflow, carry_out}, 64'd0, 4'b0101);
        end
        tick();
    endtask

    task automatic test_overflow();
        clear_inputs();
        valueToStore = 1; basicAddress = 64'h7FFF_FFFF_FFFF_FFFF; regWrite = 1; writeAddr = 5'd2;
        tick();
        clear_inputs();
        readAddr1 = 5'd2; ALUSrc = 1; dOrImm = 1; imm12 = 12'h001; ALUOp = 3'b010;
        #4;
        n_tests++;
        if ({WriteData, negative, zero, overflow, carry_out} !== {64'h8000_0000_0000_0000, 4'b1010}) begin
            n_fail++; $display("FAIL add_overflow got=%h/%b exp=%h/%b", WriteData,
                {negative, zero, overflow, carry_out}, 64'h8000_0000_0000_0000, 4'b1010);
        end
        tick();
    endtask

    task automatic test_store_load();
        clear_inputs();
        valueToStore = 1; basicAddress = 64'hDEAD_BEEF; regWrite = 1; writeAddr = 5'd3;
        tick();
        // Store reg3 to reg1+3 = 8; reading in the same cycle still sees the old word.
        clear_inputs();
        readAddr1 = 5'd1; ALUSrc = 1; dOrImm = 0; dAddr9 = 9'h003; ALUOp = 3'b010;
        reg2Loc = 0; writeAddr = 5'd3; memWrite = 1; read_enable = 1; memToReg = 1;
        #4;
        n_tests++;
        if (WriteData !== 64'd0) begin
            n_fail++; $display("FAIL store_no_bypass got=%h exp=%h", WriteData, 64'd0);
        end
        tick();
        memWrite = 0;
        #4;
        n_tests++;
        if (WriteData !== 64'hDEAD_BEEF) begin
            n_fail++; $display("FAIL load_word got=%h exp=%h", WriteData, 64'hDEAD_BEEF);
        end
        tick();
        read_enable = 0;
        #4;
        n_tests++;
        if (WriteData !== 64'd0) begin
            n_fail++; $display("FAIL load_disabled got=%h exp=%h", WriteData, 64'd0);
        end
        tick();
        memToReg = 0; dAddr9 = 9'h1FF;
        #4;
        n_tests++;
        if (WriteData !== 64'd4) begin
            n_fail++; $display("FAIL neg_offset got=%h exp=%h", WriteData, 64'd4);
        end
        tick();
    endtask

    task automatic test_r31();
        clear_inputs();
        ALUSrc = 1; dOrImm = 1; imm12 = 12'h007; ALUOp = 3'b010; regWrite = 1; writeAddr = 5'd31;
        #4;
        n_tests++;
        if (WriteData !== 64'd7) begin
            n_fail++; $display("FAIL r31_wd got=%h exp=%h", WriteData, 64'd7);
        end
        tick();
        clear_inputs();
        reg2Loc = 1; readAddr2 = 5'd31; ALUOp = 3'b000;
        #4;
        n_tests++;
        if (WriteData !== 64'd0) begin
            n_fail++; $display("FAIL r31_reads_zero got=%h exp=%h", WriteData, 64'd0);
        end
        tick();
    endtask

    task automatic test_link();
        clear_inputs();
        readAddr1 = 5'd3; ALUSrc = 1; dOrImm = 1; imm12 = 12'h123; ALUOp = 3'b010;
        memToReg = 1; read_enable = 1; valueToStore = 1; basicAddress = 64'h104;
        #4;
        n_tests++;
        if (WriteData !== 64'h104) begin
            n_fail++; $display("FAIL link_value got=%h exp=%h", WriteData, 64'h104);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        reset = 1; regWrite = 1; writeAddr = 5'd1; ALUSrc = 1; dOrImm = 1; imm12 = 12'h0AA;
        ALUOp = 3'b010; memWrite = 1;
        tick();
        clear_inputs();
        readAddr1 = 5'd1; ALUSrc = 1; dOrImm = 1; ALUOp = 3'b010;
        #4;
        n_tests++;
        if (WriteData !== 64'd0) begin
            n_fail++; $display("FAIL reset_clears_reg got=%h exp=%h", WriteData, 64'd0);
        end
        tick();
        clear_inputs();
        ALUSrc = 1; dOrImm = 0; dAddr9 = 9'h008; ALUOp = 3'b010; memToReg = 1; read_enable = 1;
        #4;
        n_tests++;
        if (WriteData !== 64'd0) begin
            n_fail++; $display("FAIL reset_clears_mem got=%h exp=%h", WriteData, 64'd0);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset        = ($urandom_range(0, 59) == 0);
            regWrite     = $urandom_range(0, 1);
            reg2Loc      = $urandom_range(0, 1);
            ALUSrc       = $urandom_range(0, 1);
            dOrImm       = $urandom_range(0, 1);
            ALUOp        = 3'($urandom_range(0, 7));
            memWrite     = $urandom_range(0, 1);
            read_enable  = ($urandom_range(0, 3) != 0);
            memToReg     = $urandom_range(0, 1);
            valueToStore = ($urandom_range(0, 3) == 0);
            readAddr1    = 5'($urandom_range(0, 31));
            readAddr2    = 5'($urandom_range(0, 31));
            writeAddr    = 5'($urandom_range(0, 31));
            dAddr9       = 9'($urandom);
            imm12        = 12'($urandom);
            basicAddress = {$urandom, $urandom};
            // Keep addresses small half the time so loads hit stored words.
            if ($urandom_range(0, 1) == 1) begin
                readAddr1 = 5'($urandom_range(28, 31));
                ALUOp     = 3'b010;
                ALUSrc    = 1;
            end
            #4;
            model_eval();
            n_tests++;
            if ({WriteData, negative, zero, overflow, carry_out} !== {e_wd, e_neg, e_zero, e_ovf, e_cy}) begin
                n_fail++;
                $display("FAIL random[%0d] got=%h/%b exp=%h/%b", n, WriteData,
                    {negative, zero, overflow, carry_out}, e_wd, {e_neg, e_zero, e_ovf, e_cy});
            end
            tick();
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_addi();
        test_sub();
        test_overflow();
        test_store_load();
        test_r31();
        test_link();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_movement.md
# data_movement

Single-cycle LEGv8-style execute/memory/write-back datapath slice. It reads two 64-bit registers and selects the second ALU operand. It executes one ALU operation, optionally accesses a doubleword data memory, and selects the value written back to the register file. Control signals come from the external instruction decoder. The ALU flags go to the branch/flag logic.

## Interface
Parameters:
- MEM_WORDS, 128 — data memory depth in 64-bit doublewords (power of two).

Ports:
- clk  in  1  — single clock; all state updates on rising edge.
- reset  in  1  — synchronous, active-high; one clock; reset is synchronous and active-high.
- regWrite  in  1  — write WriteData to register writeAddr at clock edge.
- reg2Loc  in  1  — second read port address select: 0 = writeAddr, 1 = readAddr2.
- ALUSrc  in  1  — ALU B select: 0 = ReadData2, 1 = extended immediate.
- dOrImm  in  1  — immediate select: 0 = sext(dAddr9), 1 = sext(imm12).
- ALUOp  in  3  — ALU operation.
- memWrite  in  1  — store ReadData2 to memory at clock edge.
- read_enable  in  1  — enable memory read data.
- memToReg  in  1  — 0 = ALU result, 1 = memory read data.
- valueToStore  in  1  — 0 = memToReg path, 1 = basicAddress (link value).
- readAddr1, readAddr2, writeAddr  in  5 each  — register addresses.
- dAddr9  in  9  — load/store offset.
- imm12  in  12  — ALU immediate.
- basicAddress  in  64  — link address (PC+4) for write-back.
- negative, zero, overflow, carry_out  out  1 each  — ALU flags.
- WriteData  out  64  — selected write-back value.

## Operation
- Register file: 32 × 64 bits. Two combinational read ports. Register 31 always reads 0, and writes to it are ignored.
- The port 2 address is selected by reg2Loc. reg2Loc=0 selects writeAddr, which is the STUR source register.
- Extension: the 9-bit and 12-bit immediates are sign-extended to 64 bits.
- ALUOp values:
  - 000 → result = B.
  - 010 → A+B.
  - 011 → A−B, computed as A + ~B + 1.
  - 100 → A&B.
  - 101 → A|B.
  - 110 → A^B.
  - 001 and 111 → result 0.
- Flags:
  - negative = result[63].
  - zero = (result == 0).
  - carry_out = carry out of bit 63 for add/sub, 0 otherwise.
  - overflow = signed overflow for add/sub, 0 otherwise.
- Data memory is addressed by the ALU result.
  - Word index = result[3 +: log2(MEM_WORDS)].
  - result[2:0] is ignored, so accesses are forced aligned.
  - Upper bits are ignored, so addresses wrap modulo the memory size.
  - Transfers are always 8 bytes.
- Memory read data is combinational: mem[index] when read_enable=1, else 64'h0.
- Write-back: WriteData = valueToStore ? basicAddress : (memToReg ? read_data : result).

## Timing
- WriteData, all flags and read_data are combinational from inputs and current state, with zero latency.
- At the rising clock edge:
  - If reset=1, all registers and all memory words are cleared to 0. Reset has priority over regWrite and memWrite.
  - Otherwise, if regWrite=1 and writeAddr≠31, reg[writeAddr] ← WriteData.
  - If memWrite=1, mem[index] ← ReadData2.
- There is no read-during-write bypass. A read in the same cycle as a write returns the old value, and the new value is visible the next cycle.
- Reset values:
  - WriteData is 0 after reset with all selects 0, readAddr1=31 and ALUOp=000.
  - The flags then follow the combinational inputs. zero=1 when result is 0.
- Simultaneous regWrite and memWrite in one cycle are both performed.

## Structure
- Shared package holds:
  - XLEN=64 and ZERO_REG=5'd31.
  - The ALUOp constants ALU_PASS_B, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR.
- Sub-modules: alu (combinational, flags included), datamem, and mux2x5 for the register address select. The 64-bit selects are inline.
- The register file lives inside data_movement.

## Test plan
- Reset, then readAddr1=31, ALUSrc=1, dOrImm=1, imm12=12'h005, ALUOp=010, regWrite=1, writeAddr=1 → WriteData=5. After the edge, reg1 reads 5.
- Subtract: reg1=5, readAddr2=1, reg2Loc=1, ALUSrc=0, ALUOp=011, readAddr1=1 → result 0, zero=1, carry_out=1, overflow=0.
- Overflow: reg2=64'h7FFF_FFFF_FFFF_FFFF plus immediate 1 with ALUOp=010 → result 64'h8000…0, negative=1, overflow=1, carry_out=0.
- Store/load:
  - Store: reg3=64'hDEAD_BEEF, base reg1=5, dAddr9=9'h003 (address 8), reg2Loc=0 with writeAddr=3, memWrite=1.
  - Load: next cycle, same address with memToReg=1 and read_enable=1 → WriteData=64'hDEAD_BEEF.
  - Negative offset: dAddr9=9'h1FF gives address reg−1.
- Writes to register 31 are ignored: regWrite with writeAddr=31 and value 7 → register 31 still reads 0.
- Link and reset:
  - valueToStore=1, basicAddress=64'h104 → WriteData=64'h104 regardless of the ALU.
  - Asserting reset mid-operation clears reg1 and memory to 0 on the next edge.
